// File: rtl/audio_resampler_if.sv
// audio_resampler_if -- controller/SRAM side bundle for the playback resampler.
//   master : playback controller + SRAM model (drives i_*, observes o_*)
//   slave  : audio_resampler
// Signals: play/start/end/speed/slow control, sample_req frame strobe, SRAM
// read port (addr, oe_n, data), sample output with valid strobe, status
// (cur_addr, busy, done, overrun).
interface audio_resampler_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              i_play;
    logic [ADDR_W-1:0] i_start_addr;
    logic [ADDR_W-1:0] i_end_addr;
    logic [3:0]        i_speed;
    logic              i_slow;
    logic              i_sample_req;
    logic [DATA_W-1:0] i_sram_data;
    logic [ADDR_W-1:0] o_sram_addr;
    logic              o_sram_oe_n;
    logic [DATA_W-1:0] o_sample;
    logic              o_sample_valid;
    logic [ADDR_W-1:0] o_cur_addr;
    logic              o_busy;
    logic              o_done;
    logic              o_overrun;

    modport master (
        output i_play, i_start_addr, i_end_addr, i_speed, i_slow, i_sample_req, i_sram_data,
        input  o_sram_addr, o_sram_oe_n, o_sample, o_sample_valid, o_cur_addr, o_busy,
               o_done, o_overrun
    );
    modport slave (
        input  i_play, i_start_addr, i_end_addr, i_speed, i_slow, i_sample_req, i_sram_data,
        output o_sram_addr, o_sram_oe_n, o_sample, o_sample_valid, o_cur_addr, o_busy,
               o_done, o_overrun
    );
endinterface

// File: rtl/audio_resampler.sv
// audio_resampler -- SRAM-to-DAC playback stage: one output sample per DAC
// frame request, with normal, fast (skip N) and slow (repeat N) playback.
// Ports: i_clk, i_rst (async, active-high), rs (audio_resampler_if.slave).
// Build option: RESAMPLER_LINEAR_INTERP_EN enables linear interpolation in
// slow mode (FETCH_B + CALC with a restoring divider); without it slow mode
// is zero-order hold and FETCH_B/CALC are never entered.
module audio_resampler #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int MAX_SPEED = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    audio_resampler_if.slave rs
);
    typedef enum logic [2:0] {IDLE, WAIT_REQ, FETCH_A, FETCH_B, CALC, EMIT} state_t;

    state_t            state_q;
    logic              play_q, ph_q, oe_n_q, valid_q, done_q, ovr_q;
    logic [ADDR_W-1:0] cur_q, sram_addr_q;
    logic [3:0]        k_q;
    logic [DATA_W-1:0] sample_q;

    logic play_rise, play_fall;
    assign play_rise = rs.i_play & ~play_q;
    assign play_fall = ~rs.i_play & play_q;

    // Speed normalisation and next-position computation for EMIT.
    logic [3:0]    n_eff, k_cl, k_inc, k_nxt, step;
    logic          slow_span, past_end;
    logic [ADDR_W:0] nxt;
    always_comb begin
        n_eff = rs.i_speed;
        if (rs.i_speed == 4'd0)                n_eff = 4'd1;
        else if (rs.i_speed > 4'(MAX_SPEED))   n_eff = 4'(MAX_SPEED);
        slow_span = rs.i_slow && (n_eff != 4'd1);
        // N may shrink mid-span; keep the phase inside the new span.
        k_cl  = (k_q >= n_eff) ? n_eff - 4'd1 : k_q;
        k_inc = k_cl + 4'd1;
        k_nxt = 4'd0;
        step  = n_eff;
        if (slow_span) begin
            if (k_inc == n_eff) begin
                step = 4'd1;
            end else begin
                step  = 4'd0;
                k_nxt = k_inc;
            end
        end
        // One extra bit so a wrap past the top of memory still reads as "past end".
        nxt      = {1'b0, cur_q} + (ADDR_W+1)'(step);
        past_end = nxt > {1'b0, rs.i_end_addr};
    end

`ifdef RESAMPLER_LINEAR_INTERP_EN
    localparam int CW = $clog2(DATA_W + 1);
    logic [DATA_W-1:0] a_q, div_a, div_b, dvd_q, quot, mag, res;
    logic [ADDR_W:0]   b_addr;
    logic              b_past, neg_q, ge;
    logic signed [DATA_W:0] diff;
    logic [DATA_W+3:0] prod;
    logic [3:0]        rem_q, div_n_q, rem_n;
    logic [4:0]        trial;
    logic [CW-1:0]     cnt_q;

    // Operands are taken straight off the SRAM bus on the cycle that loads
    // the divider, so CALC starts iterating immediately.
    always_comb begin
        b_addr = {1'b0, cur_q} + (ADDR_W+1)'(1);
        b_past = b_addr > {1'b0, rs.i_end_addr};
        div_a  = (state_q == FETCH_A) ? rs.i_sram_data : a_q;
        div_b  = (state_q == FETCH_B) ? rs.i_sram_data : div_a;
        diff   = $signed({div_b[DATA_W-1], div_b}) - $signed({div_a[DATA_W-1], div_a});
        mag    = DATA_W'(diff[DATA_W] ? -diff : diff);
        prod   = (DATA_W+4)'(mag) * (DATA_W+4)'(k_cl);
        // |diff|*k < N*2^DATA_W, so the quotient fits DATA_W bits and the bits
        // above DATA_W are already a valid partial remainder (< N).
        trial  = {rem_q, dvd_q[DATA_W-1]};
        ge     = trial >= {1'b0, div_n_q};
        rem_n  = ge ? 4'(trial - {1'b0, div_n_q}) : trial[3:0];
        quot   = {dvd_q[DATA_W-2:0], ge};
        res    = neg_q ? a_q - quot : a_q + quot;
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            play_q      <= 1'b0;
            ph_q        <= 1'b0;
            cur_q       <= '0;
            k_q         <= '0;
            sram_addr_q <= '0;
            oe_n_q      <= 1'b1;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
`ifdef RESAMPLER_LINEAR_INTERP_EN
            a_q <= '0; dvd_q <= '0; rem_q <= '0; div_n_q <= 4'd1; neg_q <= 1'b0; cnt_q <= '0;
`endif
        end else begin
            play_q  <= rs.i_play;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (play_rise)
                ovr_q <= 1'b0;
            else if (rs.i_sample_req && state_q != IDLE && state_q != WAIT_REQ)
                ovr_q <= 1'b1;

            if (play_fall) begin
                // Abort: cur_q is left alone so the controller can resume from it.
                state_q <= IDLE;
                oe_n_q  <= 1'b1;
                ph_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (play_rise) begin
                        cur_q <= rs.i_start_addr;
                        k_q   <= '0;
                        if (rs.i_start_addr > rs.i_end_addr) done_q  <= 1'b1;
                        else                                 state_q <= WAIT_REQ;
                    end
                    WAIT_REQ: if (rs.i_sample_req) begin
                        sram_addr_q <= cur_q;
                        oe_n_q      <= 1'b0;
                        ph_q        <= 1'b0;
                        state_q     <= FETCH_A;
                    end
                    // Two cycles per read: address out, then capture the data.
                    FETCH_A: begin
                        ph_q <= ~ph_q;
                        if (ph_q) begin
`ifdef RESAMPLER_LINEAR_INTERP_EN
                            a_q <= rs.i_sram_data;
                            if (slow_span && b_past) begin
                                oe_n_q <= 1'b1;
                                rem_q <= prod[DATA_W+3:DATA_W]; dvd_q <= prod[DATA_W-1:0];
                                neg_q <= diff[DATA_W]; div_n_q <= n_eff; cnt_q <= CW'(DATA_W);
                                state_q <= CALC;
                            end else if (slow_span) begin
                                sram_addr_q <= b_addr[ADDR_W-1:0];
                                state_q     <= FETCH_B;
                            end else begin
                                sample_q <= rs.i_sram_data;
                                valid_q  <= 1'b1;
                                oe_n_q   <= 1'b1;
                                state_q  <= EMIT;
                            end
`else
                            sample_q <= rs.i_sram_data;
                            valid_q  <= 1'b1;
                            oe_n_q   <= 1'b1;
                            state_q  <= EMIT;
`endif
                        end
                    end
`ifdef RESAMPLER_LINEAR_INTERP_EN
                    FETCH_B: begin
                        ph_q <= ~ph_q;
                        if (ph_q) begin
                            oe_n_q <= 1'b1;
                            rem_q <= prod[DATA_W+3:DATA_W]; dvd_q <= prod[DATA_W-1:0];
                            neg_q <= diff[DATA_W]; div_n_q <= n_eff; cnt_q <= CW'(DATA_W);
                            state_q <= CALC;
                        end
                    end
                    CALC: begin
                        rem_q <= rem_n;
                        dvd_q <= quot;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            sample_q <= res;
                            valid_q  <= 1'b1;
                            state_q  <= EMIT;
                        end
                    end
`endif
                    EMIT: begin
                        if (past_end) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cur_q   <= nxt[ADDR_W-1:0];
                            k_q     <= k_nxt;
                            state_q <= WAIT_REQ;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rs.o_sram_addr    = sram_addr_q;
    assign rs.o_sram_oe_n    = oe_n_q;
    assign rs.o_sample       = sample_q;
    assign rs.o_sample_valid = valid_q;
    assign rs.o_cur_addr     = cur_q;
    assign rs.o_busy         = (state_q != IDLE);
    assign rs.o_done         = done_q;
    assign rs.o_overrun      = ovr_q;
endmodule

// File: tb/tb_audio_resampler.sv
// tb_audio_resampler -- directed, table-driven bench for audio_resampler,
// plus hand sequences for pause/abort, empty range, overrun and async reset.
// Expected slow-mode values follow RESAMPLER_LINEAR_INTERP_EN when defined.
`timescale 1ns/1ps
module tb_audio_resampler;
    localparam int AW = 20;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    audio_resampler_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();
    audio_resampler #(.ADDR_W(AW), .DATA_W(DW), .MAX_SPEED(8)) dut (
        .i_clk(clk), .i_rst(rst), .rs(ifc)
    );

    // SRAM model: address seen at a clock edge, data valid for the next cycle.
    logic [DW-1:0] mem [0:63];
    always @(posedge clk) ifc.i_sram_data <= mem[ifc.o_sram_addr[5:0]];

    int vcount = 0, dcount = 0;
    always @(posedge clk) begin
        if (ifc.o_sample_valid) vcount <= vcount + 1;
        if (ifc.o_done)         dcount <= dcount + 1;
    end

    int n_cmp = 0, n_err = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_play(input logic [AW-1:0] st, input logic [AW-1:0] en,
                              input logic [3:0] spd, input logic sl);
        ifc.i_play = 1'b0;
        tick(); tick();
        ifc.i_start_addr = st;
        ifc.i_end_addr   = en;
        ifc.i_speed      = spd;
        ifc.i_slow       = sl;
        ifc.i_play       = 1'b1;
        tick();
    endtask

    // One frame request; returns the emitted sample and o_done one cycle after EMIT.
    task automatic do_req(input string nm, output logic [DW-1:0] smp, output logic dn);
        int lat;
        ifc.i_sample_req = 1'b1;
        tick();
        ifc.i_sample_req = 1'b0;
        lat = 0;
        while (!ifc.o_sample_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({nm, " valid"}, 32'(ifc.o_sample_valid), 32'd1);
        chk({nm, " latency<=24"}, 32'(lat + 1 <= 24), 32'd1);
        smp = ifc.o_sample;
        tick();
        dn = ifc.o_done;
        for (int j = lat; j < 32; j++) tick();
    endtask

    typedef struct {
        string         name;
        logic [AW-1:0] st, en;
        logic [3:0]    spd;
        logic          sl;
        int            nreq;
        logic [DW-1:0] exp [5];
        logic          dn;
        logic [AW-1:0] cur;
    } vec_t;
    vec_t vecs [7];

    task automatic setv(input int i, input string nm, input logic [AW-1:0] st, input logic [AW-1:0] en,
                        input logic [3:0] spd, input logic sl, input int n,
                        input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                        input logic [DW-1:0] e3, input logic [DW-1:0] e4,
                        input logic dn, input logic [AW-1:0] cur);
        vecs[i].name = nm; vecs[i].st = st; vecs[i].en = en; vecs[i].spd = spd; vecs[i].sl = sl;
        vecs[i].nreq = n;
        vecs[i].exp[0] = e0; vecs[i].exp[1] = e1; vecs[i].exp[2] = e2;
        vecs[i].exp[3] = e3; vecs[i].exp[4] = e4;
        vecs[i].dn = dn; vecs[i].cur = cur;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] smp;
        logic          dn;
        int            v0, d0;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int i = 0; i < 10; i++) mem[i] = DW'(i * 10);
        mem[16] = 16'd100; mem[17] = 16'd200; mem[18] = 16'd300; mem[19] = 16'd400;
        mem[32] = 16'd0;   mem[33] = 16'd400;
        mem[40] = 16'd100; mem[41] = 16'hFF9C;   // -100

        setv(0, "normal",  20'h10, 20'h13, 4'd1,  1'b0, 4, 16'd100, 16'd200, 16'd300, 16'd400, 16'd0, 1'b1, 20'h13);
        setv(1, "fast3",   20'h00, 20'h09, 4'd3,  1'b0, 4, 16'd0, 16'd30, 16'd60, 16'd90, 16'd0, 1'b1, 20'h09);
        setv(2, "clamp12", 20'h00, 20'h09, 4'd12, 1'b0, 2, 16'd0, 16'd80, 16'd0, 16'd0, 16'd0, 1'b1, 20'h08);
        setv(3, "speed0",  20'h10, 20'h11, 4'd0,  1'b1, 2, 16'd100, 16'd200, 16'd0, 16'd0, 16'd0, 1'b1, 20'h11);
`ifdef RESAMPLER_LINEAR_INTERP_EN
        setv(4, "slow4",   20'h20, 20'h21, 4'd4,  1'b1, 5, 16'd0, 16'd100, 16'd200, 16'd300, 16'd400, 1'b0, 20'h21);
        setv(5, "slowneg", 20'h28, 20'h29, 4'd3,  1'b1, 3, 16'd100, 16'd34, 16'hFFDF, 16'd0, 16'd0, 1'b0, 20'h29);
`else
        setv(4, "slow4",   20'h20, 20'h21, 4'd4,  1'b1, 5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd400, 1'b0, 20'h21);
        setv(5, "slowneg", 20'h28, 20'h29, 4'd3,  1'b1, 3, 16'd100, 16'd100, 16'd100, 16'd0, 16'd0, 1'b0, 20'h29);
`endif
        setv(6, "slowlast", 20'h13, 20'h13, 4'd2, 1'b1, 2, 16'd400, 16'd400, 16'd0, 16'd0, 16'd0, 1'b1, 20'h13);

        ifc.i_play = 1'b0; ifc.i_start_addr = '0; ifc.i_end_addr = '0;
        ifc.i_speed = 4'd1; ifc.i_slow = 1'b0; ifc.i_sample_req = 1'b0;
        rst = 1'b1;
        #23;
        chk("reset oe_n",    32'(ifc.o_sram_oe_n), 32'd1);
        chk("reset outputs", {ifc.o_sample_valid, ifc.o_busy, ifc.o_done, ifc.o_overrun}, 32'd0);
        chk("reset addr",    32'(ifc.o_sram_addr | ifc.o_cur_addr), 32'd0);
        chk("reset sample",  32'(ifc.o_sample), 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            start_play(vecs[v].st, vecs[v].en, vecs[v].spd, vecs[v].sl);
            for (int i = 0; i < vecs[v].nreq; i++) begin
                do_req($sformatf("%s req%0d", vecs[v].name, i), smp, dn);
                chk($sformatf("%s sample%0d", vecs[v].name, i), 32'(smp), 32'(vecs[v].exp[i]));
                chk($sformatf("%s done%0d", vecs[v].name, i), 32'(dn),
                    32'(vecs[v].dn && (i == vecs[v].nreq - 1)));
            end
            chk($sformatf("%s cur_addr", vecs[v].name), 32'(ifc.o_cur_addr), 32'(vecs[v].cur));
        end

        // Pause while fetching: no output, no done, position kept.
        start_play(20'h10, 20'h13, 4'd1, 1'b0);
        do_req("pause pre", smp, dn);
        chk("pause pre sample", 32'(smp), 32'd100);
        v0 = vcount; d0 = dcount;
        ifc.i_sample_req = 1'b1; tick(); ifc.i_sample_req = 1'b0;
        chk("pause oe active", 32'(ifc.o_sram_oe_n), 32'd0);
        ifc.i_play = 1'b0;
        tick();
        chk("pause oe released", 32'(ifc.o_sram_oe_n), 32'd1);
        chk("pause busy", 32'(ifc.o_busy), 32'd0);
        repeat (30) tick();
        chk("pause no valid", 32'(vcount - v0), 32'd0);
        chk("pause no done", 32'(dcount - d0), 32'd0);
        chk("pause cur_addr", 32'(ifc.o_cur_addr), 32'h11);

        // Empty range: done pulses straight away and the block stays idle.
        ifc.i_start_addr = 20'h20; ifc.i_end_addr = 20'h1F; ifc.i_play = 1'b1;
        tick();
        chk("empty done", 32'(ifc.o_done), 32'd1);
        chk("empty busy", 32'(ifc.o_busy), 32'd0);
        tick();
        chk("empty done pulse", 32'(ifc.o_done), 32'd0);
        chk("empty still idle", 32'(ifc.o_busy), 32'd0);

        // Second request lands while the first is still being fetched.
        start_play(20'h10, 20'h13, 4'd1, 1'b0);
        chk("ovr clear", 32'(ifc.o_overrun), 32'd0);
        v0 = vcount;
        ifc.i_sample_req = 1'b1; tick(); ifc.i_sample_req = 1'b0; tick();
        ifc.i_sample_req = 1'b1; tick(); ifc.i_sample_req = 1'b0;
        repeat (30) tick();
        chk("ovr one valid", 32'(vcount - v0), 32'd1);
        chk("ovr sticky", 32'(ifc.o_overrun), 32'd1);
        ifc.i_play = 1'b0; tick();
        chk("ovr kept on pause", 32'(ifc.o_overrun), 32'd1);
        ifc.i_play = 1'b1; tick();
        chk("ovr cleared on play", 32'(ifc.o_overrun), 32'd0);

        // Asynchronous reset in the middle of a fetch.
        ifc.i_sample_req = 1'b1; tick(); ifc.i_sample_req = 1'b0;
        chk("rst pre oe", 32'(ifc.o_sram_oe_n), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst async oe_n",   32'(ifc.o_sram_oe_n), 32'd1);
        chk("rst async addr",   32'(ifc.o_sram_addr), 32'd0);
        chk("rst async cur",    32'(ifc.o_cur_addr), 32'd0);
        chk("rst async sample", 32'(ifc.o_sample), 32'd0);
        chk("rst async flags",  {ifc.o_sample_valid, ifc.o_busy, ifc.o_done, ifc.o_overrun}, 32'd0);
        #2 rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
